// File: rtl/scratch_mem_arbiter_if.sv
// Bundle of requester, bench-test and scratch-memory signals shared by the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface scratch_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        reqIn;
  logic [NUM_REQ*ADDR_W-1:0] rdAddrIn;
  logic [NUM_REQ*ADDR_W-1:0] wrAddrIn;
  logic [NUM_REQ*DATA_W-1:0] wrDataIn;
  logic [NUM_REQ-1:0]        wrEnIn;
  logic                      testSel;
  logic [ADDR_W-1:0]         testRdAddr;
  logic [ADDR_W-1:0]         testWrAddr;
  logic [DATA_W-1:0]         testWrData;
  logic                      testWrEn;
  logic [DATA_W-1:0]         memDoutB;
  logic [ADDR_W-1:0]         memAddrA;
  logic [DATA_W-1:0]         memDinA;
  logic                      memWeA;
  logic [ADDR_W-1:0]         memAddrB;
  logic [NUM_REQ-1:0]        grantOut;
  logic [DATA_W-1:0]         rdDataOut;
  logic [NUM_REQ-1:0]        rdValidOut;
  logic                      testActive;
  logic                      busy;

  modport slave (
    input  reqIn, rdAddrIn, wrAddrIn, wrDataIn, wrEnIn,
    input  testSel, testRdAddr, testWrAddr, testWrData, testWrEn,
    input  memDoutB,
    output memAddrA, memDinA, memWeA, memAddrB,
    output grantOut, rdDataOut, rdValidOut, testActive, busy
  );

  modport master (
    output reqIn, rdAddrIn, wrAddrIn, wrDataIn, wrEnIn,
    output testSel, testRdAddr, testWrAddr, testWrData, testWrEn,
    output memDoutB,
    input  memAddrA, memDinA, memWeA, memAddrB,
    input  grantOut, rdDataOut, rdValidOut, testActive, busy
  );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Round-robin, grant-locked arbiter sharing one scratch memory (write port A, read port B)
// between NUM_REQ datapath FSMs and an exclusive bench test port.
module scratch_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic reset,
  scratch_mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] TEST    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rdValid_q, rdValid_d;

  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  int                 candIdx;
  logic [IDX_W-1:0]   ownerNext;

  logic [ADDR_W-1:0]  rdAddrArr [NUM_REQ];
  logic [ADDR_W-1:0]  wrAddrArr [NUM_REQ];
  logic [DATA_W-1:0]  wrDataArr [NUM_REQ];

  logic [ADDR_W-1:0]  memAddrAMux;
  logic [DATA_W-1:0]  memDinAMux;
  logic               memWeAMux;
  logic [ADDR_W-1:0]  memAddrBMux;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rdAddrArr[i] = bus.rdAddrIn[i*ADDR_W +: ADDR_W];
    assign wrAddrArr[i] = bus.wrAddrIn[i*ADDR_W +: ADDR_W];
    assign wrDataArr[i] = bus.wrDataIn[i*DATA_W +: DATA_W];
  end

  // First requesting index at or after rrPtr, wrapping around.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = rrPtr_q;
    candIdx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candIdx = int'(rrPtr_q) + k;
      if (candIdx >= NUM_REQ) candIdx = candIdx - NUM_REQ;
      if (!pickValid && bus.reqIn[IDX_W'(candIdx)]) begin
        pickValid = 1'b1;
        pickIdx   = IDX_W'(candIdx);
      end
    end
  end

  assign ownerNext = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rrPtr_d = rrPtr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (bus.testSel) begin
          state_d = TEST;
        end else if (pickValid) begin
          state_d = GRANT;
          owner_d = pickIdx;
          grant_d = NUM_REQ'(1) << pickIdx;
        end
      end
      GRANT: begin
        if (!bus.reqIn[owner_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          rrPtr_d = ownerNext;
        end
      end
      RELEASE: state_d = IDLE;
      TEST:    if (!bus.testSel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data from port B lags its address by one cycle, so valid tags the previous owner.
  assign rdValid_d = (state_q == GRANT) ? (NUM_REQ'(1) << owner_q) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      rdValid_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Decoded purely from registered state, so an asserted reset silences the memory at once.
  always_comb begin
    memAddrAMux = '0;
    memDinAMux  = '0;
    memWeAMux   = 1'b0;
    memAddrBMux = '0;
    case (state_q)
      GRANT: begin
        memAddrAMux = wrAddrArr[owner_q];
        memDinAMux  = wrDataArr[owner_q];
        memWeAMux   = bus.wrEnIn[owner_q];
        memAddrBMux = rdAddrArr[owner_q];
      end
      TEST: begin
        memAddrAMux = bus.testWrAddr;
        memDinAMux  = bus.testWrData;
        memWeAMux   = bus.testWrEn;
        memAddrBMux = bus.testRdAddr;
      end
      default: ;
    endcase
  end

  assign bus.memAddrA   = memAddrAMux;
  assign bus.memDinA    = memDinAMux;
  assign bus.memWeA     = memWeAMux;
  assign bus.memAddrB   = memAddrBMux;
  assign bus.grantOut   = grant_q;
  assign bus.rdDataOut  = bus.memDoutB;
  assign bus.rdValidOut = rdValid_q;
  assign bus.testActive = (state_q == TEST);
  assign bus.busy       = (state_q != IDLE);

endmodule
